// File: rtl/instr_feeder.sv
// instr_feeder: steps through a synchronous instruction RAM and hands each
// instruction (plus the immediate word of an mvi) to the CPU. It pulses Run
// once per instruction, then waits for Done. It halts on the reserved HALT
// opcode, or after the word at LAST_ADDR has been consumed.
// Optional build macro: INSTR_FEEDER_TIMEOUT_EN. When it is defined, a wait for
// Done that lasts TIMEOUT cycles sets the sticky Error flag and halts.
module instr_feeder #(
  parameter logic [4:0]  LAST_ADDR = 5'd31,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Done,
  input  logic [8:0] MEM_DATA,
  output logic [4:0] ADDRESS,
  output logic [8:0] DIN,
  output logic       Run,
  output logic       Halted,
  output logic       Error,
  output logic [4:0] PC
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, WAIT, HALT
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t     state, next_state;
  logic [4:0] pc;
  logic [8:0] instr_reg;
  logic [8:0] imm_reg;
  logic       is_mvi;      // instruction in instr_reg carries an immediate
  logic       last_word;   // last word consumed was at LAST_ADDR
  logic       first_wait;  // marks the first WAIT cycle after ISSUE
  logic       timeout_hit;

`ifdef INSTR_FEEDER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] wait_cnt;
  logic          error_q;

  // A Done that arrives on the expiring edge wins over the timeout.
  assign timeout_hit = (state == WAIT) && !Done && (wait_cnt == CW'(TIMEOUT - 1));
  assign Error       = error_q;

  // Count consecutive WAIT cycles; latch the sticky timeout flag
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) error_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  // TIMEOUT has no effect in this build. It is referenced here only so both
  // builds share one parameter list.
  assign timeout_hit = (TIMEOUT == 0) & 1'b0;
  assign Error       = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (Start) next_state = FETCH;
      FETCH:     next_state = LATCH;
      LATCH: begin
        if (MEM_DATA[8:6] == OP_HALT)
          next_state = HALT;
        else if (MEM_DATA[8:6] == OP_MVI)
          next_state = (pc == LAST_ADDR) ? HALT : FETCH_IMM;
        else
          next_state = ISSUE;
      end
      FETCH_IMM: next_state = LATCH_IMM;
      LATCH_IMM: next_state = ISSUE;
      ISSUE:     next_state = WAIT;
      WAIT: begin
        if (Done)             next_state = last_word ? HALT : FETCH;
        else if (timeout_hit) next_state = HALT;
      end
      HALT:      if (Start) next_state = FETCH;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode; the RAM is always addressed by PC
  always_comb begin
    Run     = (state == ISSUE);
    Halted  = (state == HALT);
    ADDRESS = pc;
    PC      = pc;
    DIN     = (state == WAIT && first_wait && is_mvi) ? imm_reg : instr_reg;
  end

  // Program counter, instruction/immediate capture and bookkeeping flags
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc         <= '0;
      instr_reg  <= '0;
      imm_reg    <= '0;
      is_mvi     <= 1'b0;
      last_word  <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (Start) pc <= '0;
        LATCH: begin
          instr_reg <= MEM_DATA;
          pc        <= pc + 5'd1;
          is_mvi    <= (MEM_DATA[8:6] == OP_MVI);
          last_word <= (pc == LAST_ADDR);
        end
        LATCH_IMM: begin
          imm_reg   <= MEM_DATA;
          pc        <= pc + 5'd1;
          last_word <= (pc == LAST_ADDR);
        end
        ISSUE:     first_wait <= 1'b1;
        WAIT:      first_wait <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Testbench for instr_feeder (LAST_ADDR=4, TIMEOUT=8). A transaction-level
// model derives, from the RAM image, when each Run pulse, immediate and halt
// must appear. A single negedge process compares the DUT against the model and
// plays the CPU role by returning Done. Directed scenarios add literal checks.
module tb_instr_feeder;

  localparam logic [4:0]  LAST = 5'd4;
  localparam int unsigned TMO  = 8;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic       Done = 1'b0;
  logic [8:0] MEM_DATA;
  logic [4:0] ADDRESS;
  logic [8:0] DIN;
  logic       Run, Halted, Error;
  logic [4:0] PC;

  logic [8:0] ram [32];

  int checks = 0;
  int errors = 0;

  instr_feeder #(.LAST_ADDR(LAST), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
    .MEM_DATA(MEM_DATA), .ADDRESS(ADDRESS), .DIN(DIN), .Run(Run),
    .Halted(Halted), .Error(Error), .PC(PC)
  );

  always #5 Clock = ~Clock;

  // Synchronous instruction RAM: data one cycle after the address
  always @(posedge Clock) MEM_DATA <= ram[ADDRESS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  int         cyc = 0, exp_run = -1, halt_cyc = -1, err_from = -1;
  int         done_at = -1, imm_chk = -1, cpu_dly = 2, run_cnt = 0;
  bit         m_busy = 0, m_last = 0, exp_mvi = 0, rst_seen = 0, rst_chk = 0, inj_done = 0;
  logic [4:0] m_addr = '0, exp_pc = '0, halt_pc = '0;
  logic [8:0] exp_word = '0, exp_imm = '0;
  logic [8:0] cap_run_din = '0, cap_imm_din = '0;
  logic [4:0] cap_run_pc = '0;

  // Schedule the next transaction, starting from a Start or Done seen at cycle c
  task automatic plan(input int c);
    logic [8:0] w;
    w = ram[m_addr];
    if (w[8:6] == 3'b111 || (w[8:6] == 3'b001 && m_addr == LAST)) begin
      halt_cyc = c + 3;
      halt_pc  = m_addr + 5'd1;
    end else if (w[8:6] == 3'b001) begin
      exp_word = w;
      exp_imm  = ram[m_addr + 5'd1];
      m_last   = ((m_addr + 5'd1) == LAST);
      m_addr   = m_addr + 5'd2;
      exp_mvi  = 1;
      exp_run  = c + 5;
    end else begin
      exp_word = w;
      m_last   = (m_addr == LAST);
      m_addr   = m_addr + 5'd1;
      exp_mvi  = 0;
      exp_run  = c + 3;
    end
    exp_pc = m_addr;
  endtask

  // Compare process and CPU responder
  initial forever begin
    bit exp_h;
    @(negedge Clock);
    cyc++;
    if (rst_seen) begin
      if (rst_chk) begin
        check("rst_pc", PC, 0);
        check("rst_addr", ADDRESS, 0);
        check("rst_din", DIN, 0);
        check("rst_err", Error, 0);
        check("rst_halted", Halted, 0);
        rst_chk = 0;
      end
      check("run", Run, cyc == exp_run);
      if (Run === 1'b1) begin
        run_cnt++;
        cap_run_din = DIN;
        cap_run_pc  = PC;
      end
      if (cyc == exp_run) begin
        check("run_din", DIN, exp_word);
        check("run_pc", PC, exp_pc);
        check("run_addr", ADDRESS, exp_pc);
        if (exp_mvi) imm_chk = cyc + 1;
        if (cpu_dly > 0) done_at = cyc + cpu_dly;
        else begin
`ifdef INSTR_FEEDER_TIMEOUT_EN
          halt_cyc = cyc + 1 + TMO;
          halt_pc  = exp_pc;
          err_from = halt_cyc;
`endif
        end
        exp_run = -1;
      end
      if (cyc == imm_chk) begin
        check("imm_din", DIN, exp_imm);
        cap_imm_din = DIN;
        imm_chk = -1;
      end
      exp_h = (halt_cyc >= 0 && cyc >= halt_cyc);
      check("halted", Halted, exp_h);
      if (exp_h) check("halt_pc", PC, halt_pc);
      check("error", Error, (err_from >= 0 && cyc >= err_from));
    end
    Done = 1'b0;
    if (cyc == done_at) begin
      Done = 1'b1;
      done_at = -1;
      if (m_last) begin
        halt_cyc = cyc + 1;
        halt_pc  = m_addr;
      end else plan(cyc);
    end
    if (inj_done) begin
      Done = 1'b1;
      inj_done = 0;
    end
    if (!Resetn) begin
      exp_run = -1; halt_cyc = -1; err_from = -1; done_at = -1; imm_chk = -1;
      m_busy = 0; rst_seen = 1; rst_chk = 1;
    end else if (Start && (!m_busy || (halt_cyc >= 0 && cyc >= halt_cyc))) begin
      m_busy = 1;
      m_addr = '0;
      halt_cyc = -1;
      plan(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_ram(input logic [8:0] v);
    for (int i = 0; i < 32; i++) ram[i] = v;
  endtask

  task automatic pulse_start();
    @(posedge Clock); #1 Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (Halted !== 1'b1 && n < 300) begin
      @(posedge Clock); #1;
      n++;
    end
    check(name, Halted, 1);
  endtask

  task automatic do_reset();
    @(posedge Clock); #1 Resetn = 1'b0;
    @(posedge Clock); #1 Resetn = 1'b1;
  endtask

  initial begin
    int base, n;
    clear_ram(9'h000);
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    check("init_pc", PC, 0);
    check("init_halted", Halted, 0);
    check("init_run", Run, 0);
    check("init_din", DIN, 0);
    check("init_err", Error, 0);

    // mv R1,R0; add R2,R1; HALT
    clear_ram(9'h000);
    ram[0] = 9'h008; ram[1] = 9'h091; ram[2] = 9'h1C0;
    cpu_dly = 2; base = run_cnt;
    pulse_start();
    wait_halt("s1_halt");
    check("s1_runs", run_cnt - base, 2);
    check("s1_pc", PC, 3);
    inj_done = 1;                       // stray Done in HALT is ignored
    repeat (4) begin @(posedge Clock); #1; end
    check("s1_stray_halted", Halted, 1);

    // mvi R3 with immediate 77
    clear_ram(9'h000);
    ram[0] = 9'h058; ram[1] = 9'd77; ram[2] = 9'h1C0;
    base = run_cnt;
    pulse_start();
    wait_halt("s2_halt");
    check("s2_runs", run_cnt - base, 1);
    check("s2_run_din", cap_run_din, 9'h058);
    check("s2_run_pc", cap_run_pc, 2);
    check("s2_imm_din", cap_imm_din, 9'd77);
    check("s2_pc", PC, 3);

    // All mv R0,R0: halts after LAST, then restarts at 0
    clear_ram(9'h000);
    base = run_cnt;
    pulse_start();
    wait_halt("s3_halt");
    check("s3_runs", run_cnt - base, 5);
    check("s3_pc", PC, 5);
    pulse_start();
    wait_halt("s3_halt2");
    check("s3_runs2", run_cnt - base, 10);
    check("s3_pc2", PC, 5);

    // mvi opcode at LAST: not issued
    clear_ram(9'h000);
    ram[4] = 9'h058;
    base = run_cnt;
    pulse_start();
    wait_halt("s4_halt");
    check("s4_runs", run_cnt - base, 4);
    check("s4_pc", PC, 5);

    // mvi whose immediate sits at LAST: issued, then halt
    clear_ram(9'h000);
    ram[3] = 9'h058; ram[4] = 9'd5;
    base = run_cnt;
    pulse_start();
    wait_halt("s4b_halt");
    check("s4b_runs", run_cnt - base, 4);
    check("s4b_imm", cap_imm_din, 9'd5);
    check("s4b_pc", PC, 5);

    // Done arriving on the TIMEOUT-th WAIT cycle completes normally
    clear_ram(9'h000);
    ram[0] = 9'h091; ram[1] = 9'h1C0;
    cpu_dly = TMO; base = run_cnt;
    pulse_start();
    wait_halt("s7_halt");
    check("s7_runs", run_cnt - base, 1);
    check("s7_err", Error, 0);
    check("s7_pc", PC, 2);

    // Reset during WAIT of an add; a later Done is ignored
    clear_ram(9'h000);
    ram[0] = 9'h091;
    cpu_dly = 0;
    pulse_start();
    n = 0;
    while (Run !== 1'b1 && n < 20) begin @(posedge Clock); #1; n++; end
    check("s5_run_seen", Run, 1);
    repeat (2) begin @(posedge Clock); #1; end
    Resetn = 1'b0;
    @(posedge Clock); #1 Resetn = 1'b1;
    check("s5_pc", PC, 0);
    check("s5_halted", Halted, 0);
    check("s5_run", Run, 0);
    base = run_cnt;
    inj_done = 1;
    repeat (10) begin @(posedge Clock); #1; end
    check("s5_runs", run_cnt - base, 0);
    check("s5_pc2", PC, 0);
    check("s5_halted2", Halted, 0);

    // Done never returns
    clear_ram(9'h000);
    ram[0] = 9'h091; ram[1] = 9'h1C0;
    cpu_dly = 0;
    pulse_start();
    repeat (TMO + 12) begin @(posedge Clock); #1; end
`ifdef INSTR_FEEDER_TIMEOUT_EN
    check("s6_halted", Halted, 1);
    check("s6_err", Error, 1);
    check("s6_pc", PC, 1);
    cpu_dly = 2;
    pulse_start();
    wait_halt("s6_halt2");
    check("s6_err_sticky", Error, 1);
    check("s6_pc2", PC, 2);
`else
    check("s6_halted", Halted, 0);
    check("s6_err", Error, 0);
    check("s6_pc", PC, 1);
`endif
    do_reset();
    check("s6_rst_err", Error, 0);
    check("s6_rst_halted", Halted, 0);
    cpu_dly = 2;

    repeat (3) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
